run_controller: RTL and testbench

Synthesizable run controller for the pipeline CPU. It generalises the fixed one-shot reset-and-clock harness into a parametrised sequencer that can be restarted. It holds NUM_CH downstream domains (pipeline, instruction memory, data memory, …) in reset, releases them in a staggered order, counts run cycles and stops on a CPU halt or a watchdog timeout. It sits between the board/bench reset and the `cpu` top, and feeds each domain's synchronous reset.

---
 rtl/run_ctrl_pkg.sv | 29 ++
 rtl/sat_counter.sv | 21 ++
 rtl/run_controller.sv | 126 ++++++++++++
 tb/tb_run_controller.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state type and parameter helpers for run_controller
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HOLD,
      RELEASE,
      RUN,
      DONE,
      FAULT
   } run_state_t;

   // RELEASE must cover the last channel's release slot plus one settling cycle.
   function automatic int release_len(input int num_ch, input int stagger);
      return stagger * (num_ch - 1) + 1;
   endfunction

   function automatic bit params_ok(input int num_ch, input int hold_cycles,
                                    input int stagger, input int cnt_w,
                                    input int timeout);
      bit ok;
      ok = (num_ch >= 1) && (hold_cycles >= 1) && (stagger >= 0) &&
           (cnt_w >= 1) && (timeout >= 1);
      if (cnt_w < 31)
         ok = ok && (timeout < (1 << cnt_w));
      return ok;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear and enable
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/run_controller.sv
// rtl/run_controller.sv - staggered reset release and run sequencer; watchdog via RUN_CTRL_WATCHDOG_EN
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int HOLD_CYCLES = 4,
   parameter int STAGGER     = 2,
   parameter int CNT_W       = 32,
   parameter int TIMEOUT     = 100000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              halt,
   output logic [NUM_CH-1:0] ch_reset,
   output logic              running,
   output logic              done,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam int               REL_LEN   = release_len(NUM_CH, STAGGER);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_LEN - 1);

   generate
      if (!params_ok(NUM_CH, HOLD_CYCLES, STAGGER, CNT_W, TIMEOUT)) begin : g_bad_params
         $error("run_controller: illegal parameter combination");
      end
   endgenerate

   run_state_t        state, state_next;
   logic [CNT_W-1:0]  phase;
   logic [CNT_W-1:0]  rel_phase;
   logic              phase_clear, phase_en;
   logic              cnt_clear, cnt_en;
   logic [NUM_CH-1:0] ch_reset_next;
   logic              fault_flag;

`ifdef RUN_CTRL_WATCHDOG_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
`endif

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE, FAULT: begin
            if (start)
               state_next = HOLD;
         end
         HOLD: begin
            if (phase == HOLD_LAST)
               state_next = RELEASE;
         end
         RELEASE: begin
            if (phase == REL_LAST)
               state_next = RUN;
         end
         RUN: begin
            if (halt)
               state_next = DONE;
`ifdef RUN_CTRL_WATCHDOG_EN
            else if (cycle_count == TIMEOUT_LAST)
               state_next = FAULT;
`endif
         end
         default: state_next = IDLE;
      endcase

      // One phase counter serves HOLD and RELEASE; it restarts on every state change.
      phase_clear = (state_next != state);
      phase_en    = (state == HOLD) || (state == RELEASE);
      cnt_clear   = (state_next == HOLD) && (state != HOLD);
      cnt_en      = (state == RUN);

      // Outputs are registered, so release decisions use the phase of the next cycle.
      rel_phase = (state == RELEASE) ? phase + CNT_W'(1) : '0;

      ch_reset_next = '1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (state_next == RUN)
            ch_reset_next[i] = 1'b0;
         else if (state_next == RELEASE)
            ch_reset_next[i] = !(CNT_W'(STAGGER * i) <= rel_phase);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         ch_reset   <= '1;
         running    <= 1'b0;
         done       <= 1'b0;
         fault_flag <= 1'b0;
      end else begin
         state      <= state_next;
         ch_reset   <= ch_reset_next;
         running    <= (state_next == RUN);
         done       <= (state_next == DONE);
         fault_flag <= (state_next == FAULT);
      end
   end

`ifdef RUN_CTRL_WATCHDOG_EN
   assign timeout = fault_flag;
`else
   assign timeout = 1'b0;
`endif

   sat_counter #(.W(CNT_W)) u_phase_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (phase_clear),
      .enable (phase_en),
      .count  (phase)
   );

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .count  (cycle_count)
   );

endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - directed self-checking bench for run_controller
module tb_run_controller;

   logic        clk     = 1'b0;
   logic        reset   = 1'b0;
   logic        start_a = 1'b0;
   logic        halt_a  = 1'b0;
   logic        start_b = 1'b0;
   logic        halt_b  = 1'b0;

   logic [1:0]  ch_a;
   logic        run_a, done_a, to_a;
   logic [31:0] cnt_a;

   logic [3:0]  ch_b;
   logic        run_b, done_b, to_b;
   logic [31:0] cnt_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   run_controller #(.TIMEOUT(50)) dut_a (
      .clk         (clk),
      .reset       (reset),
      .start       (start_a),
      .halt        (halt_a),
      .ch_reset    (ch_a),
      .running     (run_a),
      .done        (done_a),
      .timeout     (to_a),
      .cycle_count (cnt_a)
   );

   run_controller #(.NUM_CH(4), .STAGGER(0), .TIMEOUT(1000)) dut_b (
      .clk         (clk),
      .reset       (reset),
      .start       (start_b),
      .halt        (halt_b),
      .ch_reset    (ch_b),
      .running     (run_b),
      .done        (done_b),
      .timeout     (to_b),
      .cycle_count (cnt_b)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Start pulse, then wait until the first RUN cycle (HOLD 4 + RELEASE 3).
   task automatic launch_a();
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
      check("launch_done_clr", done_a, 1'b0);
      check("launch_to_clr", to_a, 1'b0);
      check("launch_cnt_clr", cnt_a, 32'd0);
      tick(7);
      check("launch_running", run_a, 1'b1);
      check("launch_cnt0", cnt_a, 32'd0);
   endtask

   initial begin
      // power-on reset
      tick(3);
      check("por_ch_a", ch_a, 2'b11);
      check("por_run", run_a, 1'b0);
      check("por_done", done_a, 1'b0);
      check("por_to", to_a, 1'b0);
      check("por_cnt", cnt_a, 32'd0);
      check("por_ch_b", ch_b, 4'hF);
      reset = 1'b1;
      tick(1);

      // staggered release: t is the cycle index after the start edge k
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
      for (int t = 1; t <= 8; t++) begin
         check($sformatf("rel_ch_t%0d", t), ch_a, (t <= 4) ? 2'b11 : (t <= 6) ? 2'b10 : 2'b00);
         check($sformatf("rel_run_t%0d", t), run_a, (t == 8));
         if (t < 8)
            tick(1);
      end
      check("run_cnt0", cnt_a, 32'd0);

      // halt at cycle_count 20
      tick(20);
      check("cnt20", cnt_a, 32'd20);
      halt_a = 1'b1;
      tick(1);
      halt_a = 1'b0;
      check("halt_done", done_a, 1'b1);
      check("halt_run", run_a, 1'b0);
      check("halt_cnt", cnt_a, 32'd21);
      check("halt_ch", ch_a, 2'b11);
      tick(5);
      check("sticky_done", done_a, 1'b1);
      check("sticky_cnt", cnt_a, 32'd21);
      check("sticky_ch", ch_a, 2'b11);

      // restart from DONE, then async reset mid-run
      launch_a();
      tick(10);
      check("rerun_cnt10", cnt_a, 32'd10);
      reset = 1'b0;
      #2;
      check("areset_ch", ch_a, 2'b11);
      check("areset_run", run_a, 1'b0);
      check("areset_cnt", cnt_a, 32'd0);
      check("areset_done", done_a, 1'b0);
      tick(1);
      reset = 1'b1;
      tick(1);

`ifdef RUN_CTRL_WATCHDOG_EN
      launch_a();
      tick(49);
      check("wd_cnt49", cnt_a, 32'd49);
      check("wd_run49", run_a, 1'b1);
      tick(1);
      check("wd_to", to_a, 1'b1);
      check("wd_cnt", cnt_a, 32'd50);
      check("wd_run", run_a, 1'b0);
      check("wd_ch", ch_a, 2'b11);
      launch_a();
      tick(49);
      halt_a = 1'b1;
      tick(1);
      halt_a = 1'b0;
      check("tie_done", done_a, 1'b1);
      check("tie_to", to_a, 1'b0);
      check("tie_cnt", cnt_a, 32'd50);
`else
      launch_a();
      tick(50);
      check("nowd_run50", run_a, 1'b1);
      check("nowd_to50", to_a, 1'b0);
      check("nowd_cnt50", cnt_a, 32'd50);
      tick(10);
      check("nowd_cnt60", cnt_a, 32'd60);
      halt_a = 1'b1;
      tick(1);
      halt_a = 1'b0;
      check("nowd_done", done_a, 1'b1);
      check("nowd_cnt61", cnt_a, 32'd61);
`endif

      // four channels, zero stagger: all released together, RELEASE is one cycle
      start_b = 1'b1;
      tick(1);
      start_b = 1'b0;
      for (int t = 1; t <= 6; t++) begin
         check($sformatf("b_ch_t%0d", t), ch_b, (t <= 4) ? 4'hF : 4'h0);
         check($sformatf("b_run_t%0d", t), run_b, (t == 6));
         if (t < 6)
            tick(1);
      end
      tick(55);
      check("b_run55", run_b, 1'b1);
      check("b_to55", to_b, 1'b0);
      check("b_cnt55", cnt_b, 32'd55);
      halt_b = 1'b1;
      tick(1);
      halt_b = 1'b0;
      check("b_done", done_b, 1'b1);
      check("b_cnt56", cnt_b, 32'd56);
      check("b_ch_done", ch_b, 4'hF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
